// File: rtl/ex_stage_md.sv
// Execute stage of the pipelined MIPS core: forwarding ALU, RegDst select, EX/MEM register,
// and a multi-cycle multiply/divide unit that owns the HI/LO registers.
module ex_stage_md #(
    parameter int WIDTH      = 32,
    parameter int RADDR      = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_m,
    input  logic             flush_e,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic             ALUSrcE,
    input  logic             RegDstE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [2:0]       ALUControlE,
    input  logic [2:0]       MdOpE,
    input  logic [RADDR-1:0] RsE,
    input  logic [RADDR-1:0] RtE,
    input  logic [RADDR-1:0] RdE,
    input  logic [4:0]       shamtE,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] SignImmE,
    input  logic [WIDTH-1:0] ResultW,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic [RADDR-1:0] WriteRegE,
    output logic [RADDR-1:0] WriteRegM,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic             md_stall,
    output logic             md_busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // The issue cycle counts as the first multiply cycle, so MUL lasts MUL_CYCLES-1 cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             mul_signed_q, mul_signed_d;
    logic             neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

    logic             reg_write_m_q, reg_write_m_d, mem_to_reg_m_q, mem_to_reg_m_d;
    logic             mem_write_m_q, mem_write_m_d;
    logic [RADDR-1:0] write_reg_m_q, write_reg_m_d;
    logic [WIDTH-1:0] alu_out_m_q, alu_out_m_d, write_data_m_q, write_data_m_d;

    logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_result, ex_result;
    logic             md_start, md_is_div, div_signed;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic [WIDTH-1:0] rem_step, quot_step, quot_final, rem_final;
    logic             unused_rs;

    assign unused_rs = ^RsE;
    assign WriteRegE = RegDstE ? RdE : RtE;
    assign md_busy   = (state_q != IDLE);
    assign md_stall  = md_busy && (MdOpE != 3'd0) && (MdOpE != 3'd7);
    assign md_start  = (MdOpE >= MD_MULT) && (MdOpE <= MD_DIVU) && !stall_m && !flush_e;
    assign md_is_div = (MdOpE == MD_DIV) || (MdOpE == MD_DIVU);
    assign div_signed = (MdOpE == MD_DIV);

    // NOTE: every signal driven in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_out_m_q;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_out_m_q;
            default: fwd_b = RD2E;
        endcase
        src_b = ALUSrcE ? SignImmE : fwd_b;
    end

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000:  alu_result = src_a & src_b;
            3'b001:  alu_result = src_a | src_b;
            3'b010:  alu_result = src_a + src_b;
            3'b110:  alu_result = src_a - src_b;
            3'b111:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b011:  alu_result = src_b << shamtE;
            3'b100:  alu_result = src_b >> shamtE;
            3'b101:  alu_result = src_a ^ src_b;
            default: alu_result = '0;
        endcase
        ex_result = alu_result;
        if (MdOpE == MD_MFHI) begin
            ex_result = hi_q;
        end else if (MdOpE == MD_MFLO) begin
            ex_result = lo_q;
        end
    end

    // Live operands feed the multiplier at issue so a single-cycle multiply needs no extra state.
    always_comb begin
        if (state_q == IDLE) begin
            mul_a      = src_a;
            mul_b      = fwd_b;
            mul_signed = (MdOpE == MD_MULT);
        end else begin
            mul_a      = a_q;
            mul_b      = b_q;
            mul_signed = mul_signed_q;
        end
        ext_a   = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
        ext_b   = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
        product = ext_a * ext_b;
    end

    // One restoring step on magnitudes; the top bit of the difference is the borrow.
    always_comb begin
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        if (!rem_diff[WIDTH]) begin
            rem_step  = rem_diff[WIDTH-1:0];
            quot_step = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step  = rem_shift[WIDTH-1:0];
            quot_step = {quot_q[WIDTH-2:0], 1'b0};
        end
        quot_final = neg_quot_q ? -quot_step : quot_step;
        rem_final  = neg_rem_q ? -rem_step : rem_step;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        mul_signed_d = mul_signed_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        neg_quot_d   = neg_quot_q;
        neg_rem_d    = neg_rem_q;
        div0_d       = div0_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    if (md_is_div) begin
                        state_d    = DIV;
                        cnt_d      = DIV_LOAD;
                        a_d        = src_a;
                        b_d        = (div_signed && fwd_b[WIDTH-1]) ? -fwd_b : fwd_b;
                        quot_d     = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
                        rem_d      = '0;
                        neg_quot_d = div_signed && (src_a[WIDTH-1] ^ fwd_b[WIDTH-1]);
                        neg_rem_d  = div_signed && src_a[WIDTH-1];
                        div0_d     = (fwd_b == '0);
                    end else if (MUL_CYCLES == 1) begin
                        {hi_d, lo_d} = product;
                    end else begin
                        state_d      = MUL;
                        cnt_d        = MUL_LOAD;
                        a_d          = src_a;
                        b_d          = fwd_b;
                        mul_signed_d = (MdOpE == MD_MULT);
                    end
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV: begin
                rem_d  = rem_step;
                quot_d = quot_step;
                if (cnt_q == '0) begin
                    hi_d    = div0_q ? a_q : rem_final;
                    lo_d    = div0_q ? '1 : quot_final;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bubbles clear only the controls; the data fields are don't-care and simply follow EX.
    always_comb begin
        reg_write_m_d  = reg_write_m_q;
        mem_to_reg_m_d = mem_to_reg_m_q;
        mem_write_m_d  = mem_write_m_q;
        write_reg_m_d  = write_reg_m_q;
        alu_out_m_d    = alu_out_m_q;
        write_data_m_d = write_data_m_q;
        if (!stall_m) begin
            alu_out_m_d    = ex_result;
            write_data_m_d = fwd_b;
            write_reg_m_d  = WriteRegE;
            if (flush_e || md_stall) begin
                reg_write_m_d  = 1'b0;
                mem_to_reg_m_d = 1'b0;
                mem_write_m_d  = 1'b0;
            end else begin
                reg_write_m_d  = RegWriteE;
                mem_to_reg_m_d = MemtoRegE;
                mem_write_m_d  = MemWriteE;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            mul_signed_q   <= 1'b0;
            quot_q         <= '0;
            rem_q          <= '0;
            neg_quot_q     <= 1'b0;
            neg_rem_q      <= 1'b0;
            div0_q         <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            write_reg_m_q  <= '0;
            alu_out_m_q    <= '0;
            write_data_m_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            mul_signed_q   <= mul_signed_d;
            quot_q         <= quot_d;
            rem_q          <= rem_d;
            neg_quot_q     <= neg_quot_d;
            neg_rem_q      <= neg_rem_d;
            div0_q         <= div0_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            mem_write_m_q  <= mem_write_m_d;
            write_reg_m_q  <= write_reg_m_d;
            alu_out_m_q    <= alu_out_m_d;
            write_data_m_q <= write_data_m_d;
        end
    end

    assign RegWriteM  = reg_write_m_q;
    assign MemtoRegM  = mem_to_reg_m_q;
    assign MemWriteM  = mem_write_m_q;
    assign WriteRegM  = write_reg_m_q;
    assign ALUOutM    = alu_out_m_q;
    assign WriteDataM = write_data_m_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed corner cases plus randomized traffic against
// a cycle-level behavioural model built from plain arithmetic.
module tb_ex_stage_md;

    localparam int WIDTH      = 32;
    localparam int RADDR      = 5;
    localparam int MUL_CYCLES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic stall_m, flush_e, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [2:0] ALUControlE, MdOpE;
    logic [RADDR-1:0] RsE, RtE, RdE;
    logic [4:0] shamtE;
    logic [WIDTH-1:0] RD1E, RD2E, SignImmE, ResultW;
    logic RegWriteM, MemtoRegM, MemWriteM;
    logic [RADDR-1:0] WriteRegE, WriteRegM;
    logic [WIDTH-1:0] ALUOutM, WriteDataM;
    logic md_stall, md_busy;

    always #5 clk = ~clk;

    ex_stage_md #(.WIDTH(WIDTH), .RADDR(RADDR), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_e(flush_e),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUControlE(ALUControlE), .MdOpE(MdOpE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .shamtE(shamtE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .ResultW(ResultW),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .md_stall(md_stall), .md_busy(md_busy)
    );

    int errors = 0;
    int checks = 0;
    logic last_stall;

    // Reference model state: EX/MEM contents, HI/LO, and cycles left until the pending result lands.
    logic m_reg_write, m_mem_to_reg, m_mem_write, m_data_valid;
    logic [RADDR-1:0] m_write_reg;
    logic [WIDTH-1:0] m_alu_out, m_write_data, m_hi, m_lo, m_pend_hi, m_pend_lo;
    int m_busy_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_reg_write = 0; m_mem_to_reg = 0; m_mem_write = 0; m_data_valid = 1;
        m_write_reg = '0; m_alu_out = '0; m_write_data = '0;
        m_hi = '0; m_lo = '0; m_pend_hi = '0; m_pend_lo = '0; m_busy_left = 0;
    endtask

    task automatic set_nop();
        stall_m = 0; flush_e = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
        ALUSrcE = 0; RegDstE = 0; ForwardAE = 0; ForwardBE = 0; ALUControlE = 3'b010;
        MdOpE = 0; RsE = 1; RtE = 2; RdE = 3; shamtE = 0;
        RD1E = '0; RD2E = '0; SignImmE = '0; ResultW = '0;
    endtask

    function automatic logic [WIDTH-1:0] fwd(input logic [1:0] sel, input logic [WIDTH-1:0] rv);
        case (sel)
            2'b01:   return ResultW;
            2'b10:   return m_alu_out;
            default: return rv;
        endcase
    endfunction

    // One clock: compare combinational outputs at the negedge, advance the model, compare
    // registered outputs 1ns after the posedge.
    task automatic step();
        logic [WIDTH-1:0] a, b, sb, alu, res, nh, nl;
        logic exp_busy, exp_stall, issue, bubble;
        logic [63:0] p;
        longint sa, sbv;
        @(negedge clk);
        exp_busy  = (m_busy_left > 0);
        exp_stall = exp_busy && (MdOpE >= 3'd1) && (MdOpE <= 3'd6);
        last_stall = md_stall;
        check("WriteRegE", WriteRegE, RegDstE ? RdE : RtE);
        check("md_busy", md_busy, exp_busy);
        check("md_stall", md_stall, exp_stall);

        a  = fwd(ForwardAE, RD1E);
        b  = fwd(ForwardBE, RD2E);
        sb = ALUSrcE ? SignImmE : b;
        case (ALUControlE)
            3'b000:  alu = a & sb;
            3'b001:  alu = a | sb;
            3'b010:  alu = a + sb;
            3'b110:  alu = a - sb;
            3'b111:  alu = ($signed(a) < $signed(sb)) ? 32'd1 : 32'd0;
            3'b011:  alu = sb << shamtE;
            3'b100:  alu = sb >> shamtE;
            default: alu = a ^ sb;
        endcase
        res = (MdOpE == 3'd5) ? m_hi : (MdOpE == 3'd6) ? m_lo : alu;

        issue = !exp_busy && (MdOpE >= 3'd1) && (MdOpE <= 3'd4) && !stall_m && !flush_e;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        nh = '0; nl = '0;
        case (MdOpE)
            3'd1: begin p = sa * sbv; {nh, nl} = p; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = p; end
            3'd3: begin
                if (b == 0) begin nh = a; nl = '1; end
                else begin nl = 32'(sa / sbv); nh = 32'(sa % sbv); end
            end
            3'd4: begin
                if (b == 0) begin nh = a; nl = '1; end
                else begin nl = a / b; nh = a % b; end
            end
            default: ;
        endcase

        @(posedge clk);
        #1;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
        end else if (issue) begin
            m_pend_hi = nh; m_pend_lo = nl;
            m_busy_left = (MdOpE <= 3'd2) ? MUL_CYCLES - 1 : WIDTH;
            if (m_busy_left == 0) begin m_hi = nh; m_lo = nl; end
        end
        if (!stall_m) begin
            bubble = flush_e || exp_stall;
            m_reg_write  = bubble ? 1'b0 : RegWriteE;
            m_mem_to_reg = bubble ? 1'b0 : MemtoRegE;
            m_mem_write  = bubble ? 1'b0 : MemWriteE;
            m_alu_out    = res;
            m_write_data = b;
            m_write_reg  = RegDstE ? RdE : RtE;
            m_data_valid = !bubble;
        end
        check("RegWriteM", RegWriteM, m_reg_write);
        check("MemtoRegM", MemtoRegM, m_mem_to_reg);
        check("MemWriteM", MemWriteM, m_mem_write);
        if (m_data_valid) begin
            check("ALUOutM", ALUOutM, m_alu_out);
            check("WriteDataM", WriteDataM, m_write_data);
            check("WriteRegM", WriteRegM, m_write_reg);
        end
    endtask

    task automatic alu_op(input logic [2:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resw,
                          input logic [4:0] sh);
        set_nop();
        RegWriteE = 1; ALUControlE = ctrl; RD1E = rd1; RD2E = rd2;
        ForwardAE = fa; ForwardBE = fb; ResultW = resw; shamtE = sh;
        step();
    endtask

    task automatic md_issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        set_nop();
        MdOpE = op; RD1E = rs; RD2E = rt;
        step();
    endtask

    // Present MFHI/MFLO until it leaves EX; counts the stalled cycles (bounded).
    task automatic md_read(input logic [2:0] op, input string name, input int exp_stalls,
                           input logic [31:0] exp_val);
        int n;
        set_nop();
        MdOpE = op; RegWriteE = 1; RegDstE = 1; RdE = 5'd9;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (!last_stall) break;
            n++;
        end
        check({name, "_stall_cycles"}, n, exp_stalls);
        check(name, ALUOutM, exp_val);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 16)) - 32'd8;
            1:       return 32'd0;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        int r;
        stall_m     = ($urandom_range(0, 99) < 8);
        flush_e     = ($urandom_range(0, 99) < 8);
        RegWriteE   = 1'($urandom_range(0, 1));
        MemtoRegE   = 1'($urandom_range(0, 1));
        MemWriteE   = 1'($urandom_range(0, 1));
        ALUSrcE     = 1'($urandom_range(0, 1));
        RegDstE     = 1'($urandom_range(0, 1));
        ForwardAE   = 2'($urandom_range(0, 3));
        ForwardBE   = 2'($urandom_range(0, 3));
        ALUControlE = 3'($urandom_range(0, 7));
        RsE = 5'($urandom); RtE = 5'($urandom); RdE = 5'($urandom);
        shamtE   = 5'($urandom);
        RD1E     = pick_operand();
        RD2E     = pick_operand();
        SignImmE = $urandom;
        ResultW  = pick_operand();
        r = $urandom_range(0, 99);
        if (r < 10)      MdOpE = 3'($urandom_range(1, 4));
        else if (r < 18) MdOpE = 3'($urandom_range(5, 6));
        else if (r < 20) MdOpE = 3'd7;
        else             MdOpE = 3'd0;
        if (MdOpE >= 3'd1 && MdOpE <= 3'd4) RegWriteE = 0;
        if (!m_data_valid) begin
            if (ForwardAE == 2'b10) ForwardAE = 2'b00;
            if (ForwardBE == 2'b10) ForwardBE = 2'b00;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "time limit reached");
    end

    initial begin
        set_nop();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_RegWriteM", RegWriteM, 1'b0);
        check("reset_ALUOutM", ALUOutM, 32'h0);
        check("reset_WriteDataM", WriteDataM, 32'h0);
        check("reset_WriteRegM", WriteRegM, 5'h0);
        check("reset_md_busy", md_busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Forwarding: B from ALUOutM, then A from ResultW.
        alu_op(3'b010, 32'd3, 32'd4, 2'b00, 2'b00, 32'd0, 5'd0);
        check("add_seed", ALUOutM, 32'd7);
        alu_op(3'b010, 32'd5, 32'd999, 2'b00, 2'b10, 32'd0, 5'd0);
        check("add_fwd_b_aluoutm", ALUOutM, 32'd12);
        alu_op(3'b010, 32'd3, 32'd4, 2'b00, 2'b00, 32'd0, 5'd0);
        alu_op(3'b010, 32'd5, 32'd999, 2'b01, 2'b10, 32'd100, 5'd0);
        check("add_fwd_a_resultw", ALUOutM, 32'd107);

        // ALU corners.
        alu_op(3'b111, 32'h8000_0000, 32'd1, 2'b00, 2'b00, 32'd0, 5'd0);
        check("slt_signed", ALUOutM, 32'd1);
        alu_op(3'b011, 32'd0, 32'd3, 2'b00, 2'b00, 32'd0, 5'd31);
        check("sll_31", ALUOutM, 32'h8000_0000);
        alu_op(3'b110, 32'd0, 32'd1, 2'b00, 2'b00, 32'd0, 5'd0);
        check("sub_wrap", ALUOutM, 32'hFFFF_FFFF);

        // Multiply.
        md_issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        md_read(3'd5, "mult_hi", MUL_CYCLES - 1, 32'hFFFF_FFFF);
        md_read(3'd6, "mult_lo", 0, 32'hFFFF_FFFE);
        md_issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        md_read(3'd5, "multu_hi", MUL_CYCLES - 1, 32'h0000_0001);

        // Divide.
        md_issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        md_read(3'd6, "div_lo", WIDTH, 32'hFFFF_FFFD);
        md_read(3'd5, "div_hi", 0, 32'hFFFF_FFFF);
        md_issue(3'd4, 32'd7, 32'd0);
        md_read(3'd6, "divu0_lo", WIDTH, 32'hFFFF_FFFF);
        md_read(3'd5, "divu0_hi", 0, 32'd7);

        // Reset in the middle of a divide.
        md_issue(3'd3, 32'd1000, 32'd7);
        repeat (10) begin
            set_nop();
            step();
        end
        rst_n = 1'b0;
        #1;
        check("midreset_md_busy", md_busy, 1'b0);
        check("midreset_RegWriteM", RegWriteM, 1'b0);
        check("midreset_ALUOutM", ALUOutM, 32'h0);
        model_reset();
        rst_n = 1'b1;
        md_read(3'd6, "midreset_mflo", 0, 32'h0);
        md_read(3'd5, "midreset_mfhi", 0, 32'h0);

        // EX/MEM hold under stall_m with a flush pulse inside it.
        alu_op(3'b010, 32'd3, 32'd4, 2'b00, 2'b00, 32'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            set_nop();
            stall_m = 1; flush_e = (i == 1); RegWriteE = 1; MemWriteE = 1;
            RD1E = 32'd50; RD2E = 32'd60;
            step();
            check("stall_hold_aluout", ALUOutM, 32'd7);
            check("stall_hold_regwrite", RegWriteM, 1'b1);
            check("stall_hold_memwrite", MemWriteM, 1'b0);
        end
        set_nop();
        flush_e = 1; RegWriteE = 1; MemWriteE = 1;
        step();
        check("flush_bubble_regwrite", RegWriteM, 1'b0);
        check("flush_bubble_memwrite", MemWriteM, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
